mac_seq: RTL and testbench
==========================

# mac_seq

Operand sequencer and result drain for the 4-stage DSP multiply-accumulate datapath used in the YOLO layer engines. It accepts a job (length, bias, shift) and a valid/ready stream of signed operand pairs, and drives a 4-stage MAC core with correctly aligned accumulator-load control. It tracks in-flight terms and requantizes the 2*DATA_W accumulator back to DATA_W with round-half-up and saturation. The requantized result is presented on a valid/ready output port, which makes this block the producer and consumer that wraps the raw MAC pipeline.

## Interface
- DATA_W, 32, operand and output width (signed)
- LEN_W, 16, width of term count
- SHIFT_W, 6, width of requantization right-shift amount
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  job start pulse; honoured only in IDLE
- cfg_len  in  LEN_W  number of terms; latched on accepted start
- cfg_bias  in  2*DATA_W  signed initial accumulator value; latched on start
- cfg_shift  in  SHIFT_W  arithmetic right shift; latched on start
- in_valid  in  1  operand pair valid
- in_ready  out  1  operand pair accepted when in_valid && in_ready
- in_a, in_b  in  DATA_W each  signed operands
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out_data  out  DATA_W  requantized signed result
- out_acc  out  2*DATA_W  raw accumulator value for the same result
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ACCUM, DRAIN, OUT.
- IDLE: on start, latch cfg_*, clear accepted/retired counters, go to ACCUM (or DRAIN if cfg_len==0).
- ACCUM: in_ready = (accepted < len). Each handshake pushes {a,b,valid=1} into stage 1. The last accept moves the FSM to DRAIN.
- DRAIN: in_ready=0. Wait until retired == len, i.e. every term has reached the accumulator. Then register the requantized value and go to OUT.
- OUT: out_valid=1, with out_data/out_acc stable until out_ready. Handshake returns the FSM to IDLE. start is ignored while in OUT.
- Pipeline: stage 1 registers operands and the valid bit. Stage 2 registers the signed 2*DATA_W product and the valid bit. Stage 3 is the accumulator.
  - On a stage-2 valid, the accumulator loads cfg_bias + product if the term is first (ld_acc), otherwise acc + product.
  - A bubble (valid=0) never changes acc.
- len==0: acc = bias, and the result is produced from the bias alone.
- Accumulator arithmetic: wraps modulo 2^(2*DATA_W); no saturation inside the sum.
- Requantization:
  - r = (acc + (shift>0 ? 2^(shift-1) : 0)) >>> shift, computed in 2*DATA_W+1 bits.
  - out_data = r clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - out_acc = unshifted acc.
- Reset (at any time, including mid-job): state IDLE, all pipeline valid bits 0, counters 0, acc 0. The job is dropped and no partial result is emitted.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, out_acc=0, busy=0.
- in_ready is a registered-state function only; it does not depend combinationally on in_valid.
- The first accept is possible in the cycle after start is sampled.
- Last operand accepted at edge t: product at t+2, accumulator at t+3, out_valid high from t+4.
- len==0: out_valid rises 2 cycles after start is sampled.
- Gaps in in_valid add bubbles but do not change the result. Latency counts from the last accept.
- out_ready held low: outputs hold indefinitely with no loss.
- out_valid drops the cycle after the handshake.
- A new start is accepted in the cycle after the OUT handshake (IDLE).
- Throughput is 1 term per cycle in ACCUM.

## Structure
- Shared package: FSM state encoding (IDLE=0, ACCUM=1, DRAIN=2, OUT=3) and the requantization helper constants (saturation max/min as functions of DATA_W).
- Sub-module mac_core_4stage: the operand, product, accumulator and output register chain with a combinational ld_acc select between the bias and the accumulator. It carries no control.
- mac_seq itself holds the FSM, the counters, the valid-bit shadow pipeline and the requantization register.

## Test plan
- Basic sum: len=3, bias=10, shift=0, pairs (1,4),(2,5),(3,6) back-to-back -> out_data=42, out_acc=42, out_valid 4 cycles after last accept.
- Rounding: len=1, bias=5, (1,2), shift=2 -> acc=7, out_data=2. Negative case: bias=-7, (0,0), shift=1 -> out_data=-3.
- Saturation: len=1, bias=0, (-2^31,-2^31), shift=0 -> out_acc=2^62, out_data=2^31-1. Same pair with bias=-2^63 -> out_data=-2^31.
- Bubbles and backpressure: len=4, in_valid toggling every other cycle, out_ready low for 5 cycles -> correct sum, outputs stable while stalled, a single handshake, then IDLE.
- len=0 with bias=-9, shift=0 -> out_data=-9, out_valid 2 cycles after start, in_ready never high.
- Reset mid-ACCUM after 2 of 5 accepts -> all outputs at reset values, no out_valid. A following job len=1, bias=0, (3,3) -> out_data=9.

Source files
------------

// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the mac_seq operand sequencer and its MAC core.
// Holds the FSM encoding and the saturation bounds used by requantization.
package mac_seq_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int LEN_W_DEF   = 16;
    localparam int SHIFT_W_DEF = 6;

    // Wide enough for any sensible DATA_W; callers size-cast to their own width.
    localparam int CALC_W = 130;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_e;

    function automatic logic signed [CALC_W-1:0] sat_max(input int data_w);
        logic signed [CALC_W-1:0] one;
        one = CALC_W'(1);
        return (one <<< (data_w - 1)) - one;
    endfunction

    function automatic logic signed [CALC_W-1:0] sat_min(input int data_w);
        logic signed [CALC_W-1:0] one;
        one = CALC_W'(1);
        return -(one <<< (data_w - 1));
    endfunction

endpackage

// File: rtl/mac_seq_core.sv
// Raw 4-stage MAC register chain: operands, product, accumulator, output copy.
// Purely datapath; every load enable and the bias/accumulator select come from mac_seq.
module mac_core_4stage
    import mac_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       op_ld_i,
    input  logic signed [DATA_W-1:0]   a_i,
    input  logic signed [DATA_W-1:0]   b_i,
    input  logic                       prod_ld_i,
    input  logic                       acc_en_i,
    input  logic                       ld_acc_i,
    input  logic                       bias_ld_i,
    input  logic signed [2*DATA_W-1:0] bias_i,
    input  logic                       out_ld_i,
    output logic signed [2*DATA_W-1:0] acc_o,
    output logic signed [2*DATA_W-1:0] acc_out_o
);

    localparam int ACC_W = 2 * DATA_W;

    logic signed [DATA_W-1:0] a_q, b_q;
    logic signed [ACC_W-1:0]  prod_q, prod_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  acc_out_q;

    // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        prod_d = ACC_W'(a_q) * ACC_W'(b_q);
        acc_d  = acc_q;
        if (acc_en_i) begin
            acc_d = (ld_acc_i ? bias_i : acc_q) + prod_q;
        end else if (bias_ld_i) begin
            acc_d = bias_i;
        end
    end

    // NOTE: the whole chain is reset, not just acc, so no X can ever be summed into a fresh job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            prod_q    <= '0;
            acc_q     <= '0;
            acc_out_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every stage samples the previous stage's old value.
            if (op_ld_i) begin
                a_q <= a_i;
                b_q <= b_i;
            end
            if (prod_ld_i) prod_q <= prod_d;
            acc_q <= acc_d;
            if (out_ld_i) acc_out_q <= acc_q;
        end
    end

    assign acc_o     = acc_q;
    assign acc_out_o = acc_out_q;

endmodule

// File: rtl/mac_seq.sv
// Job sequencer around mac_core_4stage: operand handshake, in-flight term tracking,
// and round-half-up / saturating requantization of the accumulator onto a valid/ready port.
module mac_seq
    import mac_seq_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int SHIFT_W = SHIFT_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [LEN_W-1:0]           cfg_len,
    input  logic signed [2*DATA_W-1:0] cfg_bias,
    input  logic [SHIFT_W-1:0]         cfg_shift,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [DATA_W-1:0]   in_a,
    input  logic signed [DATA_W-1:0]   in_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [DATA_W-1:0]   out_data,
    output logic signed [2*DATA_W-1:0] out_acc,
    output logic                       busy
);

    localparam int ACC_W = 2 * DATA_W;
    localparam int EXT_W = ACC_W + 1;
    localparam logic signed [EXT_W-1:0] SAT_HI = EXT_W'(sat_max(DATA_W));
    localparam logic signed [EXT_W-1:0] SAT_LO = EXT_W'(sat_min(DATA_W));

    state_e                   state_q, state_d;
    logic [LEN_W-1:0]         len_q;
    logic [LEN_W-1:0]         accepted_q, accepted_d;
    logic [LEN_W-1:0]         retired_q, retired_d;
    logic signed [ACC_W-1:0]  bias_q;
    logic [SHIFT_W-1:0]       shift_q;
    logic                     v1_q, v2_q;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;

    logic                     start_fire, in_fire, drain_done, ld_acc;
    logic signed [ACC_W-1:0]  acc, core_bias;
    logic signed [EXT_W-1:0]  acc_ext, rnd, rsum, rshift;

    assign start_fire = (state_q == IDLE) && start;
    assign in_ready   = (state_q == ACCUM) && (accepted_q < len_q);
    assign in_fire    = in_valid && in_ready;
    assign drain_done = (state_q == DRAIN) && (retired_q == len_q);
    assign ld_acc     = v2_q && (retired_q == '0);
    // The start cycle seeds acc straight from the port so a len==0 job already holds its bias.
    assign core_bias  = start_fire ? cfg_bias : bias_q;

    always_comb begin
        state_d    = state_q;
        accepted_d = accepted_q;
        retired_d  = retired_q;
        if (start_fire) begin
            accepted_d = '0;
            retired_d  = '0;
        end else begin
            if (in_fire) accepted_d = accepted_q + LEN_W'(1);
            if (v2_q)    retired_d  = retired_q + LEN_W'(1);
        end
        unique case (state_q)
            IDLE:    if (start) state_d = (cfg_len == '0) ? DRAIN : ACCUM;
            ACCUM:   if (in_fire && (accepted_q + LEN_W'(1) == len_q)) state_d = DRAIN;
            DRAIN:   if (drain_done) state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One extra bit keeps acc + rounding offset from wrapping before the shift.
    always_comb begin
        acc_ext = {acc[ACC_W-1], acc};
        rnd     = '0;
        if (shift_q != '0) rnd = EXT_W'(1) << (shift_q - SHIFT_W'(1));
        rsum    = acc_ext + rnd;
        rshift  = rsum >>> shift_q;
        if (rshift > SAT_HI)      out_data_d = SAT_HI[DATA_W-1:0];
        else if (rshift < SAT_LO) out_data_d = SAT_LO[DATA_W-1:0];
        else                      out_data_d = rshift[DATA_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            accepted_q <= '0;
            retired_q  <= '0;
            len_q      <= '0;
            bias_q     <= '0;
            shift_q    <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            accepted_q <= accepted_d;
            retired_q  <= retired_d;
            v1_q       <= in_fire;
            v2_q       <= v1_q;
            if (start_fire) begin
                len_q   <= cfg_len;
                bias_q  <= cfg_bias;
                shift_q <= cfg_shift;
            end
            if (drain_done) out_data_q <= out_data_d;
        end
    end

    mac_core_4stage #(
        .DATA_W(DATA_W)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_ld_i   (in_fire),
        .a_i       (in_a),
        .b_i       (in_b),
        .prod_ld_i (v1_q),
        .acc_en_i  (v2_q),
        .ld_acc_i  (ld_acc),
        .bias_ld_i (start_fire),
        .bias_i    (core_bias),
        .out_ld_i  (drain_done),
        .acc_o     (acc),
        .acc_out_o (out_acc)
    );

    assign out_valid = (state_q == OUT);
    assign out_data  = out_data_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mac_seq.sv
// Self-checking bench for mac_seq: directed vector table, hand-written corner sequences,
// and randomized jobs compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_mac_seq;

    localparam int DATA_W  = 32;
    localparam int LEN_W   = 16;
    localparam int SHIFT_W = 6;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       start;
    logic [LEN_W-1:0]           cfg_len;
    logic signed [2*DATA_W-1:0] cfg_bias;
    logic [SHIFT_W-1:0]         cfg_shift;
    logic                       in_valid;
    logic                       in_ready;
    logic signed [DATA_W-1:0]   in_a, in_b;
    logic                       out_valid;
    logic                       out_ready;
    logic signed [DATA_W-1:0]   out_data;
    logic signed [2*DATA_W-1:0] out_acc;
    logic                       busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int ja[8];
    int jb[8];

    typedef struct {
        int                 len;
        logic signed [63:0] bias;
        int                 shift;
        int                 a[3];
        int                 b[3];
        logic signed [31:0] exp_d;
        logic signed [63:0] exp_acc;
    } vec_t;

    vec_t vecs[9];

    mac_seq #(
        .DATA_W(DATA_W), .LEN_W(LEN_W), .SHIFT_W(SHIFT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .cfg_bias(cfg_bias),
        .cfg_shift(cfg_shift), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
        .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_acc(out_acc), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    // Reference: bias plus the sum of products mod 2^64, then round-half-up shift and clamp.
    function automatic void model_job(input int len, input logic signed [63:0] bias,
                                      input int shift, output logic signed [31:0] ed,
                                      output logic signed [63:0] eacc);
        logic signed [63:0]  acc;
        logic signed [127:0] wide;
        acc = bias;
        for (int i = 0; i < len; i++) acc = acc + longint'(ja[i]) * longint'(jb[i]);
        wide = acc;
        if (shift > 0) wide = wide + (128'sd1 <<< (shift - 1));
        wide = wide >>> shift;
        if (wide > 128'sd2147483647)       ed = 32'sh7fff_ffff;
        else if (wide < -128'sd2147483648) ed = 32'sh8000_0000;
        else                               ed = wide[31:0];
        eacc = acc;
    endfunction

    function automatic vec_t mk(input int len, input logic signed [63:0] bias, input int shift,
                                input int a0, input int b0, input int a1, input int b1,
                                input int a2, input int b2,
                                input logic signed [31:0] ed, input logic signed [63:0] eacc);
        vec_t v;
        v.len = len; v.bias = bias; v.shift = shift;
        v.a[0] = a0; v.a[1] = a1; v.a[2] = a2;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2;
        v.exp_d = ed; v.exp_acc = eacc;
        return v;
    endfunction

    task automatic apply_reset();
        start = 0; in_valid = 0; out_ready = 0;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    // Runs one job from IDLE using ja/jb; returns one cycle after the output handshake.
    task automatic run_job(input string name, input int len, input logic signed [63:0] bias,
                           input int shift, input bit gap, input int stall,
                           input logic signed [31:0] ed, input logic signed [63:0] eacc);
        int  idx, ref_cyc, feed_cyc, budget;
        bit  fire, seen_ready;
        start = 1; cfg_len = LEN_W'(len); cfg_bias = bias; cfg_shift = SHIFT_W'(shift);
        ref_cyc = cyc;
        @(posedge clk); #1;
        start = 0;
        idx = 0; feed_cyc = 0;
        while (idx < len && feed_cyc < 100) begin
            in_valid = !(gap && (feed_cyc % 2 == 1));
            in_a = ja[idx]; in_b = jb[idx];
            fire = in_valid && in_ready;
            if (fire) ref_cyc = cyc;
            @(posedge clk); #1;
            if (fire) idx++;
            feed_cyc++;
        end
        in_valid = 0;
        if (idx < len) begin
            check({name, " accept timeout"}, idx, len);
            apply_reset();
            return;
        end
        if (!gap) check({name, " feed cycles"}, feed_cyc, len);
        budget = 0; seen_ready = 0;
        while (!out_valid && budget < 20) begin
            seen_ready |= in_ready;
            @(posedge clk); #1;
            budget++;
        end
        if (!out_valid) begin
            check({name, " out_valid timeout"}, out_valid, 1);
            apply_reset();
            return;
        end
        check({name, " latency"}, cyc - ref_cyc, (len == 0) ? 2 : 4);
        check({name, " in_ready while draining"}, seen_ready, 0);
        for (int i = 0; i < stall; i++) begin
            check({name, " stall out_valid"}, out_valid, 1);
            check({name, " stall out_data"}, out_data, ed);
            check({name, " stall out_acc"}, out_acc, eacc);
            @(posedge clk); #1;
        end
        out_ready = 1;
        check({name, " out_data"}, out_data, ed);
        check({name, " out_acc"}, out_acc, eacc);
        check({name, " busy in OUT"}, busy, 1);
        @(posedge clk); #1;
        out_ready = 0;
        check({name, " out_valid after handshake"}, out_valid, 0);
        check({name, " idle after handshake"}, busy, 0);
    endtask

    initial begin
        logic signed [31:0] ed;
        logic signed [63:0] eacc;
        logic signed [63:0] bias;
        int                 len, shift;
        bit                 saw_valid;

        vecs[0] = mk(3, 10, 0, 1, 4, 2, 5, 3, 6, 42, 42);
        vecs[1] = mk(1, 5, 2, 1, 2, 0, 0, 0, 0, 2, 7);
        vecs[2] = mk(1, -7, 1, 0, 0, 0, 0, 0, 0, -3, -7);
        vecs[3] = mk(1, 0, 0, 32'sh8000_0000, 32'sh8000_0000, 0, 0, 0, 0,
                     32'sh7fff_ffff, 64'sh4000_0000_0000_0000);
        vecs[4] = mk(1, 64'sh8000_0000_0000_0000, 0, 32'sh8000_0000, 32'sh8000_0000, 0, 0, 0, 0,
                     32'sh8000_0000, 64'shc000_0000_0000_0000);
        vecs[5] = mk(0, -9, 0, 0, 0, 0, 0, 0, 0, -9, -9);
        vecs[6] = mk(1, -6, 2, 0, 0, 0, 0, 0, 0, -1, -6);
        vecs[7] = mk(1, 64'sh7fff_ffff_ffff_ffff, 63, 0, 0, 0, 0, 0, 0, 1, 64'sh7fff_ffff_ffff_ffff);
        vecs[8] = mk(2, 0, 4, 100, -3, -7, 5, 0, 0, -21, -335);

        start = 0; in_valid = 0; out_ready = 0; in_a = 0; in_b = 0;
        cfg_len = 0; cfg_bias = 0; cfg_shift = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", in_ready, 0);
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset out_acc", out_acc, 0);
        check("reset busy", busy, 0);
        rst_n = 1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            for (int k = 0; k < 3; k++) begin
                ja[k] = vecs[i].a[k];
                jb[k] = vecs[i].b[k];
            end
            run_job($sformatf("vec%0d", i), vecs[i].len, vecs[i].bias, vecs[i].shift, 0, 0,
                    vecs[i].exp_d, vecs[i].exp_acc);
        end

        // Bubbles on the input plus a long output stall.
        ja[0] = 7;  jb[0] = -3;
        ja[1] = 11; jb[1] = 13;
        ja[2] = -5; jb[2] = -5;
        ja[3] = 2;  jb[3] = 100;
        model_job(4, 1000, 3, ed, eacc);
        run_job("bubbles", 4, 1000, 3, 1, 5, ed, eacc);

        // Reset in the middle of ACCUM after two accepts.
        for (int k = 0; k < 5; k++) begin
            ja[k] = k + 1; jb[k] = k + 2;
        end
        start = 1; cfg_len = 5; cfg_bias = 100; cfg_shift = 0;
        @(posedge clk); #1;
        start = 0;
        check("midjob busy", busy, 1);
        for (int k = 0; k < 2; k++) begin
            in_valid = 1; in_a = ja[k]; in_b = jb[k];
            check("midjob in_ready", in_ready, 1);
            @(posedge clk); #1;
        end
        in_valid = 0;
        #2 rst_n = 0;
        #1;
        check("midrst in_ready", in_ready, 0);
        check("midrst out_valid", out_valid, 0);
        check("midrst out_data", out_data, 0);
        check("midrst out_acc", out_acc, 0);
        check("midrst busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1;
        saw_valid = 0;
        for (int k = 0; k < 10; k++) begin
            saw_valid |= out_valid | busy;
            @(posedge clk); #1;
        end
        check("no output after reset", saw_valid, 0);
        ja[0] = 3; jb[0] = 3;
        run_job("after_reset", 1, 0, 0, 0, 0, 9, 9);

        // Randomized jobs against the reference model.
        for (int j = 0; j < 25; j++) begin
            len = $urandom_range(0, 6);
            if ($urandom_range(0, 1) == 1) bias = {$urandom, $urandom};
            else                           bias = int'($urandom_range(0, 2000)) - 1000;
            shift = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 63))
                                                : int'($urandom_range(0, 6));
            for (int k = 0; k < 8; k++) begin
                ja[k] = ($urandom_range(0, 1) == 1) ? int'($urandom) : int'($urandom_range(0, 200)) - 100;
                jb[k] = ($urandom_range(0, 1) == 1) ? int'($urandom) : int'($urandom_range(0, 200)) - 100;
            end
            model_job(len, bias, shift, ed, eacc);
            run_job($sformatf("rand%0d", j), len, bias, shift, 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), ed, eacc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
